// File: rtl/s_p_rx.sv
// s_p_rx: I2S / left-justified serial audio receiver.
// Frames SDATA on LRCLK edges into left/right parallel words.
module s_p_rx #(
    parameter int WIDTH = 16,
    parameter int DELAY = 1
) (
    input  logic             MCLK,
    input  logic             RST,
    input  logic             BCLK,
    input  logic             LRCLK,
    input  logic             SDATA,
    output logic [WIDTH-1:0] LDATA,
    output logic [WIDTH-1:0] RDATA,
    output logic             VALID_L,
    output logic             VALID_R,
    output logic             ERR_SHORT,
    output logic             LOCKED
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        PRIME,
        WAIT_EDGE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic             lr_prev_q, lr_prev_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] ldata_q, ldata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             vl_q, vl_d;
    logic             vr_q, vr_d;
    logic             err_q, err_d;

    logic             edge_w;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] app_sr, open_sr, cls_sr;
    logic [CW-1:0]    app_cnt, open_cnt, cls_cnt;

    assign edge_w = BCLK & (LRCLK != lr_prev_q);

    // Current slot with SDATA appended; saturates once the word is full
    always_comb begin
        app_sr  = sr_q;
        app_cnt = cnt_q;
        idx     = IW'(WIDTH - 1) - cnt_q[IW-1:0];
        if (cnt_q < CW'(WIDTH)) begin
            app_sr[idx] = SDATA;
            app_cnt     = cnt_q + 1'b1;
        end
    end

    // In I2S mode the edge bit is the LSB of the closing slot,
    // in left-justified mode it is the MSB of the opening slot.
    always_comb begin
        open_sr  = '0;
        open_cnt = '0;
        cls_sr   = sr_q;
        cls_cnt  = cnt_q;
        if (DELAY != 0) begin
            cls_sr  = app_sr;
            cls_cnt = app_cnt;
        end else begin
            open_sr[WIDTH-1] = SDATA;
            open_cnt         = CW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        lr_prev_d = lr_prev_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        ldata_d   = ldata_q;
        rdata_d   = rdata_q;
        vl_d      = 1'b0;
        vr_d      = 1'b0;
        err_d     = 1'b0;
        if (BCLK) begin
            lr_prev_d = LRCLK;
            unique case (state_q)
                PRIME: begin
                    state_d = WAIT_EDGE;
                end
                WAIT_EDGE: begin
                    if (edge_w) begin
                        sr_d    = open_sr;
                        cnt_d   = open_cnt;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (edge_w) begin
                        sr_d  = open_sr;
                        cnt_d = open_cnt;
                        err_d = (cls_cnt < CW'(WIDTH));
                        if (lr_prev_q) begin
                            rdata_d = cls_sr;
                            vr_d    = 1'b1;
                        end else begin
                            ldata_d = cls_sr;
                            vl_d    = 1'b1;
                        end
                    end else begin
                        sr_d  = app_sr;
                        cnt_d = app_cnt;
                    end
                end
                default: begin
                    state_d = PRIME;
                end
            endcase
        end
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            state_q   <= PRIME;
            lr_prev_q <= 1'b0;
            sr_q      <= '0;
            cnt_q     <= '0;
            ldata_q   <= '0;
            rdata_q   <= '0;
            vl_q      <= 1'b0;
            vr_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lr_prev_q <= lr_prev_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            ldata_q   <= ldata_d;
            rdata_q   <= rdata_d;
            vl_q      <= vl_d;
            vr_q      <= vr_d;
            err_q     <= err_d;
        end
    end

    assign LDATA     = ldata_q;
    assign RDATA     = rdata_q;
    assign VALID_L   = vl_q;
    assign VALID_R   = vr_q;
    assign ERR_SHORT = err_q;
    assign LOCKED    = (state_q == RUN);

endmodule
